// File: rtl/coord_scan_ctrl.sv
// Block-coordinate scan sequencer: walks a square search window and issues one (X,Y) write per position.
// Latency: START or accepted READY -> WRITE_EN next cycle; last READY -> DONE next cycle.
// Backpressure: holds the current position in WAIT until READY; START ignored while BUSY.
// Optional: define COORD_SNAKE_SCAN_EN for serpentine row order (default build is plain raster).
module coord_scan_ctrl #(
   parameter int COORD_W = 8,
   parameter int RANGE   = 16,
   parameter int STEP    = 4
) (
   input  logic                      CLK,
   input  logic                      RST_ASYNC,
   input  logic                      START,
   input  logic                      READY,
   output logic                      WRITE_EN,
   output logic signed [COORD_W-1:0] COORD_X,
   output logic signed [COORD_W-1:0] COORD_Y,
   output logic                      LAST,
   output logic                      BUSY,
   output logic                      DONE
);

   localparam logic signed [COORD_W-1:0] C_MIN  = COORD_W'(-RANGE);
   localparam logic signed [COORD_W-1:0] C_MAX  = COORD_W'(RANGE - STEP);
   localparam logic signed [COORD_W-1:0] C_STEP = COORD_W'(STEP);

`ifdef COORD_SNAKE_SCAN_EN
   // Serpentine: the final row runs right-to-left when the row count is even.
   localparam int                        N_AXIS = (2 * RANGE) / STEP;
   localparam logic signed [COORD_W-1:0] END_X  = ((N_AXIS % 2) == 0) ? C_MIN : C_MAX;
`else
   localparam logic signed [COORD_W-1:0] END_X  = C_MAX;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t                    state;
   logic signed [COORD_W-1:0] nxt_x;
   logic signed [COORD_W-1:0] nxt_y;
   logic                      cur_last;
   logic                      nxt_last;

`ifdef COORD_SNAKE_SCAN_EN
   // High while walking a right-to-left row.
   logic                      row_odd;
`endif

   // Position that follows the one currently on the coordinate outputs.
   always_comb begin
      nxt_x = COORD_X;
      nxt_y = COORD_Y;
`ifdef COORD_SNAKE_SCAN_EN
      if (!row_odd) begin
         if (COORD_X < C_MAX) nxt_x = COORD_X + C_STEP;
         else                 nxt_y = COORD_Y + C_STEP;
      end else begin
         if (COORD_X > C_MIN) nxt_x = COORD_X - C_STEP;
         else                 nxt_y = COORD_Y + C_STEP;
      end
`else
      if (COORD_X < C_MAX) begin
         nxt_x = COORD_X + C_STEP;
      end else begin
         nxt_x = C_MIN;
         nxt_y = COORD_Y + C_STEP;
      end
`endif
   end

   // End-of-traversal detection for the current and the upcoming position.
   always_comb begin
      cur_last = (COORD_X == END_X) && (COORD_Y == C_MAX);
      nxt_last = (nxt_x == END_X) && (nxt_y == C_MAX);
   end

   // Scan FSM with all outputs registered.
   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC) begin
         state    <= IDLE;
         WRITE_EN <= 1'b0;
         LAST     <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         COORD_X  <= '0;
         COORD_Y  <= '0;
`ifdef COORD_SNAKE_SCAN_EN
         row_odd  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  state    <= ISSUE;
                  WRITE_EN <= 1'b1;
                  // A legal window always has at least two positions per axis,
                  // so the first position is never the last one.
                  LAST     <= 1'b0;
                  BUSY     <= 1'b1;
                  COORD_X  <= C_MIN;
                  COORD_Y  <= C_MIN;
`ifdef COORD_SNAKE_SCAN_EN
                  row_odd  <= 1'b0;
`endif
               end
            end
            ISSUE: begin
               WRITE_EN <= 1'b0;
               LAST     <= 1'b0;
               state    <= WAIT;
            end
            WAIT: begin
               if (READY) begin
                  if (cur_last) begin
                     state <= FIN;
                     DONE  <= 1'b1;
                  end else begin
                     state    <= ISSUE;
                     WRITE_EN <= 1'b1;
                     LAST     <= nxt_last;
                     COORD_X  <= nxt_x;
                     COORD_Y  <= nxt_y;
`ifdef COORD_SNAKE_SCAN_EN
                     if (nxt_y != COORD_Y) row_odd <= ~row_odd;
`endif
                  end
               end
            end
            FIN: begin
               DONE  <= 1'b0;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               WRITE_EN <= 1'b0;
               LAST     <= 1'b0;
               BUSY     <= 1'b0;
               DONE     <= 1'b0;
            end
         endcase
      end
   end

endmodule
